booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

Shares one combinational `radix_4_booth` multiplier, with its fixed multiplicand, among `NREQ` independent requesters. Each requester presents a multiplier operand with a valid/ready handshake. The block grants one request at a time in round-robin order, drives the operand into the multiplier for one cycle, registers the `2*WIDTH`-bit product, and returns it on a single response channel tagged with the requester index. It sits between operand producers and result consumers in place of ad-hoc per-cycle operand injection.

## Interface
Parameters:
- `WIDTH`, 32, operand width; product is `2*WIDTH`
- `NREQ`, 4, number of requesters; must be 1 or more
- `MULTIPLICAND`, `32'h55555555`, fixed multiplicand forwarded to `radix_4_booth`

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_data`  in  NREQ*WIDTH  operands; requester i uses `[i*WIDTH +: WIDTH]`
- `req_ready`  out  NREQ  one-hot grant; combinational, asserted only in IDLE
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  ID_W  index of the requester that owns the result; ID_W = max(1, clog2(NREQ))
- `rsp_result`  out  2*WIDTH  signed product, operand × MULTIPLICAND
- `busy`  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, MUL, RESP.
- **IDLE:** the arbiter picks the first i with `req_valid[i]`=1, searching from `ptr` upward and wrapping `NREQ-1`→0.
  - `req_ready[i]`=1 for that i only; all others are 0.
  - On handshake: latch `op_reg`←operand and `id_reg`←i, then go to MUL.
  - If no `req_valid` is set, stay in IDLE.
- **MUL:** the multiplier input is `op_reg` (it is 0 in every other state). Then:
  - `res_reg`←product
  - `ptr`←(i+1) mod NREQ
  - go to RESP
- **RESP:** `rsp_valid`=1, with `rsp_id`/`rsp_result` stable until accepted. When `rsp_ready`=1, go to IDLE.
- **Arithmetic:** operand and MULTIPLICAND are two's complement; the product is full `2*WIDTH` bits with no truncation or saturation.
- **Requester rule:** a requester must hold `req_valid` and data stable until granted. Dropping `req_valid` before the grant withdraws the request legally.
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `busy`=0, `ptr`=0, `op_reg`=0, state=IDLE.

## Timing
- Handshake in cycle T → `rsp_valid` rises at T+2.
- `rsp_ready` high in the first RESP cycle → accepted at T+2, IDLE at T+3, next grant possible at T+3.
- Peak throughput is one result per 3 cycles. Backpressure extends RESP indefinitely, and no new grant is issued meanwhile.
- Simultaneous requests are served strictly round-robin. A requester that was just served has lowest priority on the next arbitration.
- Wrap-around: a grant to `NREQ-1` sets `ptr`=0.
- `NREQ`=1: `ptr` stays 0 and `rsp_id`=0 always.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous); any in-flight operand or unaccepted result is discarded.
- No combinational path from `rsp_ready` to `req_ready`. `req_ready` depends only on state, `ptr` and `req_valid`.

## Structure
- Package `booth_arb_pkg`: state enum (IDLE, MUL, RESP) and an ID-width helper function `id_w(nreq)`.
- Sub-module `rr_arbiter` (`NREQ`): inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and encoded `gnt_id`; purely combinational. `ptr` is owned by the top.
- Existing `radix_4_booth` is instantiated once, with `.multiplicand(MULTIPLICAND)`.

## Test plan
- **Single request, immediate accept:** requester 0 sends operand 3 at cycle T → `rsp_valid` at T+2, `rsp_id`=0, `rsp_result`=64'h00000000_FFFFFFFF.
- **Signed operand:** requester 2 sends 32'hFFFFFFFF → `rsp_result`=64'hFFFFFFFF_AAAAAAAB, `rsp_id`=2.
- **Round-robin under contention:** all 4 requesters hold valid with operands 1, 2, 3, 4 from reset.
  - Grant order is 0, 1, 2, 3, then 0.
  - `rsp_result` values are 0x55555555, 0xAAAAAAAA, 0xFFFFFFFF, 0x1_55555554.
- **Backpressure:** `rsp_ready`=0 for 10 cycles in RESP → `rsp_valid`/data stable, `req_ready` all 0, `busy`=1; result accepted on the first cycle `rsp_ready`=1.
- **Reset mid-op:** `rst_n` asserted in MUL → all outputs are 0 in the same cycle. After release, a pending requester 1 is granted with `ptr`=0 (it is the first valid at or above 0).
- **Withdrawn request:** requester 3 raises then drops `req_valid` while the block is in RESP → requester 3 is never granted and no response carries `rsp_id`=3.

Source files
------------

// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg: shared FSM state type and ID-width helper for the booth multiplier arbiter
package booth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/radix_4_booth.sv
// radix_4_booth: combinational signed radix-4 Booth multiplier, full 2*WIDTH product
module radix_4_booth #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product
);

    // One extra group so odd widths and the top sign bits are always covered
    localparam int NG = WIDTH / 2 + 1;

    logic [2*NG:0]      m_ext;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] acc;

    always_comb begin
        m_ext = {{(2*NG-WIDTH){multiplier[WIDTH-1]}}, multiplier, 1'b0};
        a_ext = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
        acc   = '0;
        pp    = '0;
        for (int j = 0; j < NG; j++) begin
            case (m_ext[2*j +: 3])
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2*j));
        end
        product = acc;
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping
module rr_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]       req,
    input  logic [id_w(NREQ)-1:0] ptr,
    input  logic                  en,
    output logic [NREQ-1:0]       gnt,
    output logic [id_w(NREQ)-1:0] gnt_id
);

    localparam int ID_W = id_w(NREQ);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NREQ);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin sharing of one Booth multiplier among NREQ requesters
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               NREQ         = 4,
    parameter logic [WIDTH-1:0] MULTIPLICAND = 32'h55555555
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [id_w(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]      rsp_result,
    output logic                    busy
);

    localparam int ID_W = id_w(NREQ);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   op_reg;
    logic [ID_W-1:0]    id_reg, ptr, gnt_id;
    logic [2*WIDTH-1:0] res_reg, product;
    logic [NREQ-1:0]    gnt;
    logic               hs;

    // Grants are masked while reset is held so req_ready reads 0 during reset
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .en     (state == IDLE && rst_n),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    radix_4_booth #(.WIDTH(WIDTH)) u_mult (
        .multiplicand (MULTIPLICAND),
        .multiplier   ((state == MUL) ? op_reg : '0),
        .product      (product)
    );

    assign hs = |gnt;

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE && hs)        ? MUL  :
                    (state == MUL)               ? RESP :
                    (state == RESP && rsp_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_reg  <= '0;
            id_reg  <= '0;
            res_reg <= '0;
            ptr     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && hs) begin
                op_reg <= req_data[gnt_id*WIDTH +: WIDTH];
                id_reg <= gnt_id;
            end
            if (state == MUL) begin
                res_reg <= product;
                ptr     <= (id_reg == ID_W'(NREQ-1)) ? '0 : id_reg + 1'b1;
            end
        end
    end

    assign req_ready  = gnt;
    assign rsp_valid  = (state == RESP);
    assign rsp_id     = id_reg;
    assign rsp_result = res_reg;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: directed checks of grant order, timing, products, backpressure and reset
module tb_booth_mult_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_result;
    logic         busy;

    int tests = 0;
    int failed = 0;

    booth_mult_arbiter #(.WIDTH(32), .NREQ(4), .MULTIPLICAND(32'h55555555)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] v);
        req_data[i*32 +: 32] = v;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'h0);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'h0);
        chk({tag, "_id"}, 64'(rsp_id), 64'h0);
        chk({tag, "_result"}, rsp_result, 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
    endtask

    logic [3:0]  rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]  rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [63:0] rr_res [5] = '{64'h55555555, 64'hAAAAAAAA, 64'hFFFFFFFF, 64'h1_55555554, 64'h55555555};

    initial begin
        // reset state
        cyc(2);
        chk_idle_zero("reset");
        rst_n = 1'b1;

        // single request, immediate accept
        rsp_ready = 1'b1;
        set_op(0, 32'd3);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 64'(req_ready), 64'h1);
        cyc(1);
        req_valid = '0;
        chk("single_mul_busy", 64'(busy), 64'h1);
        chk("single_mul_novalid", 64'(rsp_valid), 64'h0);
        cyc(1);
        chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("single_rsp_id", 64'(rsp_id), 64'h0);
        chk("single_rsp_result", rsp_result, 64'h00000000_FFFFFFFF);
        cyc(1);
        chk("single_back_idle", 64'(busy), 64'h0);
        chk("single_rsp_drop", 64'(rsp_valid), 64'h0);

        // signed operand on requester 2
        set_op(2, 32'hFFFFFFFF);
        req_valid = 4'b0100;
        #1;
        chk("signed_ready", 64'(req_ready), 64'h4);
        cyc(1);
        req_valid = '0;
        cyc(1);
        chk("signed_rsp_id", 64'(rsp_id), 64'h2);
        chk("signed_rsp_result", rsp_result, 64'hFFFFFFFF_AAAAAAAB);
        cyc(1);

        // round-robin under contention from reset
        rst_n = 1'b0;
        set_op(0, 32'd1);
        set_op(1, 32'd2);
        set_op(2, 32'd3);
        set_op(3, 32'd4);
        req_valid = 4'b1111;
        cyc(1);
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("rr%0d_ready", g), 64'(req_ready), 64'(rr_gnt[g]));
            cyc(1);
            chk($sformatf("rr%0d_mul_ready", g), 64'(req_ready), 64'h0);
            cyc(1);
            chk($sformatf("rr%0d_valid", g), 64'(rsp_valid), 64'h1);
            chk($sformatf("rr%0d_id", g), 64'(rsp_id), 64'(rr_id[g]));
            chk($sformatf("rr%0d_result", g), rsp_result, rr_res[g]);
            cyc(1);
        end
        req_valid = '0;

        // backpressure: ptr is 1, requester 1 wins over requester 0
        rsp_ready = 1'b0;
        set_op(1, 32'd5);
        req_valid = 4'b0011;
        #1;
        chk("bp_ready", 64'(req_ready), 64'h2);
        cyc(2);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp%0d_valid", c), 64'(rsp_valid), 64'h1);
            chk($sformatf("bp%0d_result", c), rsp_result, 64'h1_AAAAAAA9);
            chk($sformatf("bp%0d_id", c), 64'(rsp_id), 64'h1);
            chk($sformatf("bp%0d_ready", c), 64'(req_ready), 64'h0);
            chk($sformatf("bp%0d_busy", c), 64'(busy), 64'h1);
            cyc(1);
        end
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        cyc(1);
        chk("bp_accepted", 64'(rsp_valid), 64'h0);
        chk("bp_wrap_ready", 64'(req_ready), 64'h1);
        req_valid = '0;
        #1;
        chk("bp_withdraw_ready", 64'(req_ready), 64'h0);

        // reset mid-operation; ptr is 2 here so requester 1 is found by wrapping
        set_op(1, 32'd7);
        req_valid = 4'b0010;
        #1;
        chk("rst_pre_ready", 64'(req_ready), 64'h2);
        cyc(1);
        chk("rst_in_mul", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("rst_mid");
        cyc(1);
        rst_n = 1'b1;
        #1;
        chk("rst_regrant", 64'(req_ready), 64'h2);
        cyc(1);
        req_valid = '0;
        cyc(1);
        chk("rst_rsp_id", 64'(rsp_id), 64'h1);
        chk("rst_rsp_result", rsp_result, 64'h2_55555553);
        cyc(1);

        // withdrawn request from requester 3 while in RESP; ptr is 2
        rsp_ready = 1'b0;
        set_op(0, 32'd2);
        req_valid = 4'b0001;
        #1;
        chk("wd_ready0", 64'(req_ready), 64'h1);
        cyc(1);
        req_valid = '0;
        cyc(1);
        set_op(3, 32'd9);
        req_valid = 4'b1000;
        #1;
        chk("wd_resp_ready", 64'(req_ready), 64'h0);
        cyc(1);
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        chk("wd_rsp_id", 64'(rsp_id), 64'h0);
        chk("wd_rsp_result", rsp_result, 64'hAAAAAAAA);
        cyc(1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("wd%0d_ready", c), 64'(req_ready), 64'h0);
            chk($sformatf("wd%0d_valid", c), 64'(rsp_valid), 64'h0);
            chk($sformatf("wd%0d_busy", c), 64'(busy), 64'h0);
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
